mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline latch of the 16-bit pipelined CPU. It sits directly upstream of the register file.
- Captures each instruction's write-back info and picks the ALU result or the memory load data.
- Drives the register file write port (regWrite, writeSpecReg, R3, inData3) for the whole cycle, so the register file's negedge write sees stable values.
- Also provides a retired-instruction counter and optional decode-stage forwarding.

Parameters:
- DATA_W, 16, datapath width. Must match the register file.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on posedge
- RST  input  1  synchronous, active-high reset
- stall  input  1  hold the current latch contents
- flush  input  1  replace the incoming instruction with a bubble
- in_valid  input  1  MEM stage holds a real instruction
- in_regWrite  input  1  instruction writes a register
- in_writeSpecReg  input  2  write target: 00 general, 01 SP, 10 IH, 11 T
- in_R3  input  3  general register index to write
- in_memToReg  input  1  1 = write memory data, 0 = write ALU result
- in_aluResult  input  DATA_W  ALU result
- in_memData  input  DATA_W  load data
- readSpecReg  input  2  decode-stage read select for port 1 (same encoding as in_writeSpecReg)
- R1  input  3  decode-stage read index, port 1
- R2  input  3  decode-stage read index, port 2
- regWrite  output  1  register file write enable
- writeSpecReg  output  2  register file write target
- R3  output  3  register file write index
- inData3  output  DATA_W  register file write data
- wb_valid  output  1  latch holds a real instruction
- retire_count  output  CNT_W  retired-instruction counter
- fwdHit1  output  1  port-1 operand must come from fwdData
- fwdHit2  output  1  port-2 operand must come from fwdData
- fwdData  output  DATA_W  forwarded value (equals inData3)

Behaviour:
- Reset: one clock, synchronous, active-high. While RST=1 at a posedge, all of the following clear to 0:
  - wb_valid, regWrite, writeSpecReg, R3, inData3, retire_count, fwdHit1, fwdHit2, fwdData.
  - RST overrides stall and flush.
- Priority at each posedge when RST=0: flush > stall > capture.
  - flush=1: wb_valid_q<=0 and wr_q<=0; data fields are don't-care.
  - flush=0, stall=1: all latch fields hold.
  - Otherwise: wb_valid_q<=in_valid; wr_q<=in_valid&in_regWrite; spec_q<=in_writeSpecReg; r3_q<=in_R3; data_q<=in_memToReg ? in_memData : in_aluResult.
- Data selection happens at capture, so inData3 is a registered value (latency 1 cycle from MEM inputs).
- Outputs:
  - regWrite=wr_q; writeSpecReg=spec_q; R3=r3_q; inData3=data_q; wb_valid=wb_valid_q.
- Write outputs are stable for the full cycle. The register file writes them at the following negedge.
- A held (stalled) entry is rewritten every cycle. The value is the same, so this is harmless.
- retire_count:
  - Increments by 1 at a posedge when wb_valid_q=1 and stall=0. This holds even if flush=1 in the same cycle: the current entry leaves and the incoming one is bubbled.
  - Wraps from all-ones to 0.
  - Holds during stall. Counts bubbles never.
- Reset mid-stall discards the held entry. No write is issued in the following cycle.

Optional Feature:
- Macro: MEM_WB_FWD_EN
- Defined: fwdData=data_q, and the hit flags are combinational from latched state:
  - fwdHit1 = wr_q & ( (readSpecReg==00 & spec_q==00 & R1==r3_q) | (readSpecReg!=00 & spec_q==readSpecReg) ).
  - fwdHit2 = wr_q & spec_q==00 & R2==r3_q (port 2 reads general registers only).
  - Decode muxes fwdData when a hit flag is set. This covers the first-half-cycle read before the negedge write.
- Not defined: fwdHit1, fwdHit2 and fwdData are tied to 0, with no comparator logic.

Test Plan:
- Reset: assert RST for 2 cycles with in_valid=1, in_regWrite=1 and stall=1 → every output is 0; retire_count=0.
- ALU write-back: in_valid=1, in_regWrite=1, spec=00, R3=5, memToReg=0, alu=0x1234, mem=0xBEEF → one cycle later regWrite=1, R3=5, inData3=0x1234, wb_valid=1; retire_count=1 after the next posedge.
- Load to SP: spec=01, memToReg=1, mem=0xBEEF → writeSpecReg=01, inData3=0xBEEF. With MEM_WB_FWD_EN and readSpecReg=01: fwdHit1=1, fwdData=0xBEEF. With readSpecReg=10: fwdHit1=0.
- Stall and flush:
  - Entry R3=2 latched, then stall=1 for 3 cycles → outputs unchanged and retire_count unchanged.
  - Then flush=1 with stall=0 → next cycle wb_valid=0, regWrite=0, and retire_count increases by 1.
  - Same cycle with stall=1 and flush=1 → flush wins.
- Forward port 2: latched general write R3=3, R2=3 → fwdHit2=1. Latched SP write with R2=3 → fwdHit2=0. regWrite=0 → both hit flags 0.
- Counter wrap: preload via 65535 retiring cycles (or a CNT_W=4 build with 15 cycles) → next retire gives retire_count=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB latch: registers write-back info (ALU/load mux at capture, 1-cycle latency) and counts retirements; stall holds, flush bubbles.
// Optional decode-stage forwarding compiled in with MEM_WB_FWD_EN; otherwise the forwarding outputs are tied to zero.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic [1:0]        in_writeSpecReg,
  input  logic [2:0]        in_R3,
  input  logic              in_memToReg,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [1:0]        readSpecReg,
  input  logic [2:0]        R1,
  input  logic [2:0]        R2,
  output logic              regWrite,
  output logic [1:0]        writeSpecReg,
  output logic [2:0]        R3,
  output logic [DATA_W-1:0] inData3,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [1:0]        spec;
    logic [2:0]        r3;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  wbEntry_t          latchQ;
  logic [CNT_W-1:0]  retireQ;
  logic [DATA_W-1:0] selData;

  assign selData = in_memToReg ? in_memData : in_aluResult;

  // Flush only has to kill valid/write; the data fields keep their old value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      latchQ <= '0;
    end else if (flush) begin
      latchQ.valid <= 1'b0;
      latchQ.wr    <= 1'b0;
    end else if (!stall) begin
      latchQ.valid <= in_valid;
      latchQ.wr    <= in_valid & in_regWrite;
      latchQ.spec  <= in_writeSpecReg;
      latchQ.r3    <= in_R3;
      latchQ.data  <= selData;
    end
  end

  // The latched entry retires whenever it is allowed to leave, flushed or not.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retireQ <= '0;
    end else if (latchQ.valid && !stall) begin
      retireQ <= retireQ + CNT_W'(1);
    end
  end

  assign regWrite     = latchQ.wr;
  assign writeSpecReg = latchQ.spec;
  assign R3           = latchQ.r3;
  assign inData3      = latchQ.data;
  assign wb_valid     = latchQ.valid;
  assign retire_count = retireQ;

`ifdef MEM_WB_FWD_EN
  logic genMatch1;
  logic specMatch1;
  logic genMatch2;

  assign genMatch1  = (readSpecReg == 2'b00) && (latchQ.spec == 2'b00) && (R1 == latchQ.r3);
  assign specMatch1 = (readSpecReg != 2'b00) && (latchQ.spec == readSpecReg);
  assign genMatch2  = (latchQ.spec == 2'b00) && (R2 == latchQ.r3);

  assign fwdHit1 = latchQ.wr & (genMatch1 | specMatch1);
  assign fwdHit2 = latchQ.wr & genMatch2;
  assign fwdData = latchQ.data;
`else
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{readSpecReg, R1, R2};

  assign fwdHit1 = 1'b0;
  assign fwdHit2 = 1'b0;
  assign fwdData = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, per-cycle comparison against a register-target model, plus literal spot checks.
module tb_mem_wb_stage;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RST, stall, flush, in_valid, in_regWrite, in_memToReg;
  logic [1:0]        in_writeSpecReg, readSpecReg;
  logic [2:0]        in_R3, R1, R2;
  logic [DATA_W-1:0] in_aluResult, in_memData;
  logic              regWrite, wb_valid, fwdHit1, fwdHit2;
  logic [1:0]        writeSpecReg;
  logic [2:0]        R3;
  logic [DATA_W-1:0] inData3, fwdData;
  logic [CNT_W-1:0]  retire_count;

  int passCnt  = 0;
  int totalCnt = 0;

  mem_wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regWrite(in_regWrite), .in_writeSpecReg(in_writeSpecReg),
    .in_R3(in_R3), .in_memToReg(in_memToReg), .in_aluResult(in_aluResult),
    .in_memData(in_memData), .readSpecReg(readSpecReg), .R1(R1), .R2(R2),
    .regWrite(regWrite), .writeSpecReg(writeSpecReg), .R3(R3), .inData3(inData3),
    .wb_valid(wb_valid), .retire_count(retire_count),
    .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdData(fwdData)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the pending write-back, the number of retired instructions, and which register it targets.
  bit mReady = 0;
  bit mValid, mWr, mDataKnown;
  int mSpec, mR3, mData, mCnt;

  // Registers are numbered 0..7 general, 9 SP, 10 IH, 11 T; a forward hit is "same register".
  function automatic int tgt(input int spec, input int idx);
    return (spec == 0) ? idx : 8 + spec;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      mValid = 0; mWr = 0; mSpec = 0; mR3 = 0; mData = 0; mCnt = 0;
      mDataKnown = 1; mReady = 1;
    end else if (mReady) begin
      if (mValid && !stall) mCnt = (mCnt + 1) % (1 << CNT_W);
      if (flush) begin
        mValid = 0; mWr = 0; mDataKnown = 0;
      end else if (!stall) begin
        mValid = in_valid;
        mWr    = in_valid && in_regWrite;
        mSpec  = int'(in_writeSpecReg);
        mR3    = int'(in_R3);
        mData  = in_memToReg ? int'(in_memData) : int'(in_aluResult);
        mDataKnown = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (mReady) begin
      bit eh1, eh2;
      int efd;
`ifdef MEM_WB_FWD_EN
      eh1 = mWr && (tgt(mSpec, mR3) == tgt(int'(readSpecReg), int'(R1)));
      eh2 = mWr && (tgt(mSpec, mR3) == tgt(0, int'(R2)));
      efd = mData;
`else
      eh1 = 0; eh2 = 0; efd = 0;
`endif
      check("m_wb_valid", wb_valid, mValid);
      check("m_regWrite", regWrite, mWr);
      check("m_retire", retire_count, mCnt);
      check("m_fwdHit1", fwdHit1, eh1);
      check("m_fwdHit2", fwdHit2, eh2);
      if (mDataKnown) begin
        check("m_writeSpecReg", writeSpecReg, mSpec);
        check("m_R3", R3, mR3);
        check("m_inData3", inData3, mData);
`ifdef MEM_WB_FWD_EN
        check("m_fwdData", fwdData, efd);
`endif
      end
`ifndef MEM_WB_FWD_EN
      check("m_fwdData", fwdData, efd);
`endif
    end
  end

  task automatic drive(input logic v, input logic rw, input logic [1:0] sp, input logic [2:0] r3,
                       input logic m2r, input logic [15:0] alu, input logic [15:0] mem);
    in_valid = v; in_regWrite = rw; in_writeSpecReg = sp; in_R3 = r3;
    in_memToReg = m2r; in_aluResult = alu; in_memData = mem;
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RST = 1; stall = 1; flush = 0; readSpecReg = 0; R1 = 0; R2 = 0;
    drive(1, 1, 2'b00, 3'd5, 0, 16'h5555, 16'h6666);
    tick(); tick();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_regWrite", regWrite, 0);
    check("rst_inData3", inData3, 0);
    check("rst_R3_spec", {R3, writeSpecReg}, 0);
    check("rst_retire", retire_count, 0);
    check("rst_fwd", {fwdHit1, fwdHit2, fwdData}, 0);

    // ALU write-back
    RST = 0; stall = 0;
    drive(1, 1, 2'b00, 3'd5, 0, 16'h1234, 16'hBEEF);
    tick();
    check("alu_regWrite", regWrite, 1);
    check("alu_R3", R3, 5);
    check("alu_inData3", inData3, 16'h1234);
    check("alu_wb_valid", wb_valid, 1);
    check("alu_retire0", retire_count, 0);

    // Load to SP
    drive(1, 1, 2'b01, 3'd0, 1, 16'h1111, 16'hBEEF);
    readSpecReg = 2'b01;
    tick();
    check("ld_retire1", retire_count, 1);
    check("ld_spec", writeSpecReg, 2'b01);
    check("ld_inData3", inData3, 16'hBEEF);
`ifdef MEM_WB_FWD_EN
    check("ld_hit1_sp", fwdHit1, 1);
    check("ld_fwdData", fwdData, 16'hBEEF);
`else
    check("ld_hit1_off", fwdHit1, 0);
    check("ld_fwdData_off", fwdData, 0);
`endif
    readSpecReg = 2'b10;
    #1;
    check("ld_hit1_ih", fwdHit1, 0);

    // Stall holds entry R3=2 for three cycles
    drive(1, 1, 2'b00, 3'd2, 0, 16'h2222, 16'h0);
    tick();
    check("st_retire2", retire_count, 2);
    stall = 1;
    drive(1, 1, 2'b00, 3'd7, 0, 16'h7777, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_R3", R3, 2);
      check("st_data", inData3, 16'h2222);
      check("st_retire", retire_count, 2);
    end
    stall = 0; flush = 1;
    tick();
    check("fl_wb_valid", wb_valid, 0);
    check("fl_regWrite", regWrite, 0);
    check("fl_retire3", retire_count, 3);

    // Flush beats stall; the held entry is not counted since stall is high
    flush = 0;
    drive(1, 1, 2'b00, 3'd4, 0, 16'h4444, 16'h0);
    tick();
    check("fs_latched", {wb_valid, regWrite, R3}, {1'b1, 1'b1, 3'd4});
    stall = 1; flush = 1;
    tick();
    check("fs_wb_valid", wb_valid, 0);
    check("fs_regWrite", regWrite, 0);
    check("fs_retire", retire_count, 3);

    // Port-2 forwarding
    stall = 0; flush = 0; R2 = 3; R1 = 3; readSpecReg = 2'b00;
    drive(1, 1, 2'b00, 3'd3, 0, 16'h3333, 16'h0);
    tick();
`ifdef MEM_WB_FWD_EN
    check("f2_gen", {fwdHit1, fwdHit2}, 2'b11);
`else
    check("f2_gen_off", {fwdHit1, fwdHit2}, 2'b00);
`endif
    drive(1, 1, 2'b01, 3'd3, 0, 16'h3434, 16'h0);
    tick();
    check("f2_sp", {fwdHit1, fwdHit2}, 2'b00);
    drive(1, 0, 2'b00, 3'd3, 0, 16'h3535, 16'h0);
    tick();
    check("f2_nowr", {regWrite, fwdHit1, fwdHit2}, 3'b000);

    // Reset in the middle of a stall drops the held entry
    drive(1, 1, 2'b00, 3'd6, 0, 16'h6666, 16'h0);
    tick();
    stall = 1; RST = 1;
    tick();
    check("rs_regWrite", regWrite, 0);
    check("rs_retire", retire_count, 0);
    RST = 0; stall = 0;
    drive(0, 1, 2'b00, 3'd6, 0, 16'h6666, 16'h0);
    tick();
    check("rs_after", {wb_valid, regWrite}, 2'b00);

    // Counter wrap
    drive(1, 0, 2'b00, 3'd1, 0, 16'h0001, 16'h0);
    repeat (65536) tick();
    check("wrap_full", retire_count, 16'hFFFF);
    tick();
    check("wrap_zero", retire_count, 0);

    tick();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
